// File: rtl/rv32i_types.sv
// Shared types for the rv32i core slice.
// Holds the dmem responder FSM encoding and LFSR seed.
package rv32i_types;

  typedef enum logic [1:0] {
    resp_idle,
    resp_wait,
    resp_send
  } dmem_resp_state_t;

  localparam logic [7:0] DMEM_LFSR_SEED = 8'hA5;

endpackage

// File: rtl/lfsr8.sv
// 8-bit Galois LFSR, polynomial x^8+x^6+x^5+x^4+1.
// Used by dmem_responder to jitter response latency.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic [7:0] state
);

  logic [7:0] fb;

  assign fb = state[0] ? 8'hB8 : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (en) begin
      state <= {1'b0, state[7:1]} ^ fb;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with fixed (or jittered) latency.
// Define DMEM_RESP_STALL_EN to add 0-3 random stall cycles.
module dmem_responder #(
  parameter int DEPTH_BITS = 10,
  parameter int LATENCY    = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic        busy,
  output logic        proto_err
);

  import rv32i_types::*;

  localparam int WORDS = 2 ** DEPTH_BITS;

  dmem_resp_state_t state, state_nx;

  logic [4:0]            cnt, cnt_nx;
  logic [4:0]            total;
  logic [1:0]            stall;
  logic                  req;
  logic                  in_idle;
  logic                  go_resp;
  logic                  viol;

  logic [DEPTH_BITS-1:0] idx_q;
  logic [3:0]            rmask_q;
  logic [3:0]            wmask_q;
  logic [31:0]           wdata_q;

  logic [DEPTH_BITS-1:0] op_idx;
  logic [3:0]            op_rmask;
  logic [3:0]            op_wmask;
  logic [31:0]           op_wdata;
  logic [31:0]           cur_word;
  logic [31:0]           wr_word;
  logic [31:0]           rdata_nx;

  logic [31:0]           mem [WORDS];

`ifdef DMEM_RESP_STALL_EN
  logic [7:0] lfsr;

  lfsr8 #(
    .SEED (DMEM_LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .state (lfsr)
  );

  assign stall = lfsr[1:0];

  logic unused_lfsr;
  assign unused_lfsr = ^lfsr[7:2];
`else
  assign stall = 2'b00;
`endif

  logic unused_addr;
  assign unused_addr =
    ^{dmem_addr[31:DEPTH_BITS+2], dmem_addr[1:0]};

  assign req     = |(dmem_rmask | dmem_wmask);
  assign in_idle = (state == resp_idle);
  assign total   = 5'(LATENCY) + {3'b000, stall};

  // With LATENCY=1 the access happens on the request edge,
  // so the operands come straight from the inputs.
  assign op_idx   = in_idle ? dmem_addr[DEPTH_BITS+1:2] : idx_q;
  assign op_rmask = in_idle ? dmem_rmask : rmask_q;
  assign op_wmask = in_idle ? dmem_wmask : wmask_q;
  assign op_wdata = in_idle ? dmem_wdata : wdata_q;

  assign cur_word = mem[op_idx];

  always_comb begin
    wr_word = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (op_wmask[i]) begin
        wr_word[8*i +: 8] = op_wdata[8*i +: 8];
      end
    end
  end

  assign rdata_nx = (|op_rmask) ? cur_word : 32'h0;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    go_resp  = 1'b0;
    unique case (state)
      resp_idle: begin
        if (req) begin
          if (total == 5'd1) begin
            state_nx = resp_send;
            go_resp  = 1'b1;
          end else begin
            state_nx = resp_wait;
            cnt_nx   = total - 5'd2;
          end
        end
      end
      resp_wait: begin
        if (cnt == 5'd0) begin
          state_nx = resp_send;
          go_resp  = 1'b1;
        end else begin
          cnt_nx = cnt - 5'd1;
        end
      end
      resp_send: state_nx = resp_idle;
      default:   state_nx = resp_idle;
    endcase
  end

  assign viol = req & (!in_idle |
                (|dmem_rmask & |dmem_wmask));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= resp_idle;
      cnt        <= '0;
      idx_q      <= '0;
      rmask_q    <= '0;
      wmask_q    <= '0;
      wdata_q    <= '0;
      dmem_rdata <= '0;
      proto_err  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (in_idle && req) begin
        idx_q   <= dmem_addr[DEPTH_BITS+1:2];
        rmask_q <= dmem_rmask;
        wmask_q <= dmem_wmask;
        wdata_q <= dmem_wdata;
      end
      dmem_rdata <= go_resp ? rdata_nx : 32'h0;
      if (viol) begin
        proto_err <= 1'b1;
      end
    end
  end

  // Gated by rst_n so a request held during reset cannot commit.
  always_ff @(posedge clk) begin
    if (go_resp && rst_n && |op_wmask) begin
      mem[op_idx] <= wr_word;
    end
  end

  assign dmem_resp = (state == resp_send);
  assign busy      = !in_idle;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder.
// Directed steps plus randomized traffic against a word-array model.
module tb_dmem_responder;

  localparam int LAT = 3;
`ifdef DMEM_RESP_STALL_EN
  localparam int STALL_MAX = 3;
`else
  localparam int STALL_MAX = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] dmem_addr = '0;
  logic [3:0]  dmem_rmask = '0;
  logic [3:0]  dmem_wmask = '0;
  logic [31:0] dmem_wdata = '0;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        busy;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [1024];

  dmem_responder #(
    .DEPTH_BITS (10),
    .LATENCY    (LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dmem_addr  (dmem_addr),
    .dmem_rmask (dmem_rmask),
    .dmem_wmask (dmem_wmask),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_resp  (dmem_resp),
    .busy       (busy),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(
    input logic [31:0] old_w,
    input logic [31:0] new_w,
    input logic [3:0]  m);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // One transaction; returns latency in cycles and the response data.
  task automatic req(input logic [31:0] a,
                     input logic [3:0]  rm,
                     input logic [3:0]  wm,
                     input logic [31:0] wd,
                     output int lat,
                     output logic [31:0] rd);
    bit busy_bad;
    @(negedge clk);
    dmem_addr  = a;
    dmem_rmask = rm;
    dmem_wmask = wm;
    dmem_wdata = wd;
    @(negedge clk);
    dmem_rmask = '0;
    dmem_wmask = '0;
    lat = 0;
    rd = 'x;
    busy_bad = 0;
    for (int k = 1; k <= 25; k++) begin
      if (k > 1) @(negedge clk);
      if (!busy) busy_bad = 1;
      if (dmem_resp) begin
        lat = k;
        rd = dmem_rdata;
        break;
      end
    end
    chk("busy_until_resp", 32'(busy_bad), 32'd0);
    chk("resp_seen", 32'(lat != 0), 32'd1);
  endtask

  task automatic chk_lat(input string tag, input int lat);
    chk(tag, 32'(lat >= LAT && lat <= LAT + STALL_MAX),
        32'd1);
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [3:0] m,
                    input logic [31:0] d);
    int l;
    logic [31:0] r;
    req(a, 4'b0000, m, d, l, r);
    chk_lat("wr_lat", l);
    chk("wr_rdata_zero", r, 32'h0);
    mdl[a[11:2]] = merge(mdl[a[11:2]], d, m);
  endtask

  task automatic rd_chk(input string tag,
                        input logic [31:0] a,
                        input logic [3:0] m,
                        input logic [31:0] exp);
    int l;
    logic [31:0] r;
    req(a, m, 4'b0000, 32'h0, l, r);
    chk_lat("rd_lat", l);
    chk(tag, r, exp);
  endtask

  initial begin
    int l;
    int pulses;
    logic [31:0] r;
    logic [31:0] a;
    logic [3:0]  m;
    logic [31:0] d;
    logic [9:0]  idx;

    for (int i = 0; i < 1024; i++) mdl[i] = 'x;

    repeat (3) @(negedge clk);
    chk("rst_resp", 32'(dmem_resp), 32'd0);
    chk("rst_rdata", dmem_rdata, 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);
    rst_n = 1'b1;

    wr(32'h10, 4'b1111, 32'hDEAD_BEEF);
    rd_chk("rd_deadbeef", 32'h10, 4'b0001, 32'hDEAD_BEEF);

    wr(32'h10, 4'b1111, 32'h1111_1111);
    wr(32'h11, 4'b0010, 32'h0000_AB00);
    rd_chk("rd_byte_merge", 32'h10, 4'b1111, 32'h1111_AB11);

    wr(32'h1000, 4'b1111, 32'h0000_0001);
    rd_chk("rd_wrap", 32'h0, 4'b1111, 32'h0000_0001);

    for (int i = 0; i < 16; i++)
      wr(32'h400 + 32'(i * 4), 4'b1111, $urandom);

    for (int n = 0; n < 100; n++) begin
      idx = 10'h100 + 10'($urandom_range(0, 15));
      a = {18'($urandom_range(0, 3)), idx, 2'($urandom)};
      m = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        wr(a, m, d);
      end else begin
        rd_chk("rand_rd", a, m, mdl[idx]);
      end
    end
    chk("rand_proto_err", 32'(proto_err), 32'd0);

    // reset one cycle after a write request
    wr(32'h30, 4'b1111, 32'h1234_5678);
    @(negedge clk);
    dmem_addr  = 32'h30;
    dmem_wmask = 4'b1111;
    dmem_wdata = 32'hCAFE_F00D;
    @(negedge clk);
    dmem_wmask = '0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_resp", 32'(dmem_resp), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rdata", dmem_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < LAT + 6; k++) begin
      @(negedge clk);
      if (dmem_resp) pulses++;
    end
    chk("mid_rst_no_resp", 32'(pulses), 32'd0);
    rd_chk("mid_rst_unchanged", 32'h30, 4'b1111,
           32'h1234_5678);
    chk("pre_viol_proto_err", 32'(proto_err), 32'd0);

    // both masks: write done, old word returned
    wr(32'h20, 4'b1111, 32'hAAAA_AAAA);
    req(32'h20, 4'b1111, 4'b1111, 32'h5555_5555, l, r);
    chk_lat("both_lat", l);
    chk("both_old_word", r, 32'hAAAA_AAAA);
    chk("both_proto_err", 32'(proto_err), 32'd1);
    rd_chk("both_written", 32'h20, 4'b1111, 32'h5555_5555);

    // request while waiting is dropped
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("clr_proto_err", 32'(proto_err), 32'd0);
    @(negedge clk);
    dmem_addr  = 32'h20;
    dmem_rmask = 4'b1111;
    @(negedge clk);
    dmem_rmask = '0;
    pulses = 0;
    @(negedge clk);
    dmem_addr  = 32'h20;
    dmem_wmask = 4'b1111;
    dmem_wdata = 32'h0BAD_0BAD;
    @(negedge clk);
    dmem_wmask = '0;
    for (int k = 0; k < 20; k++) begin
      if (dmem_resp) pulses++;
      @(negedge clk);
    end
    chk("viol_one_resp", 32'(pulses), 32'd1);
    chk("viol_proto_err", 32'(proto_err), 32'd1);
    repeat (5) @(negedge clk);
    chk("viol_sticky", 32'(proto_err), 32'd1);
    rd_chk("viol_not_written", 32'h20, 4'b1111,
           32'h5555_5555);
    chk("viol_still_sticky", 32'(proto_err), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("viol_cleared", 32'(proto_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
